// File: rtl/log2_mem_pkg.sv
// Shared definitions for the log2 lookup: supported (IN,OUT) shapes, widths and ROM depths.
package log2_mem_pkg;

   typedef enum logic [1:0] {TblNone, Tbl5x4, Tbl8x4, Tbl8x5} tbl_e;

   localparam int unsigned NumPairs = 3;
   localparam int unsigned PairIn  [NumPairs] = '{5, 8, 8};
   localparam int unsigned PairOut [NumPairs] = '{4, 4, 5};
   localparam tbl_e        PairTbl [NumPairs] = '{Tbl5x4, Tbl8x4, Tbl8x5};

   localparam int unsigned RomDepth5 = 32;
   localparam int unsigned RomDepth8 = 256;

   function automatic int unsigned out_width(input int unsigned out_w);
      return out_w + 1;
   endfunction

   function automatic tbl_e tbl_sel(input int unsigned in_w, input int unsigned out_w);
      tbl_e sel;
      sel = TblNone;
      for (int unsigned i = 0; i < NumPairs; i++) begin
         if (in_w == PairIn[i] && out_w == PairOut[i]) sel = PairTbl[i];
      end
      return sel;
   endfunction

   function automatic logic is_supported(input int unsigned in_w, input int unsigned out_w);
      return tbl_sel(in_w, out_w) != TblNone;
   endfunction

endpackage

// File: rtl/log2_mem_rom.sv
// Combinational log2(1+f) tables, one per supported (IN,OUT) pair, chosen at elaboration.
// Each range lists the inputs that round to the same output code.
module log2_mem_rom
   import log2_mem_pkg::*;
#(
   parameter int unsigned IN  = 8,
   parameter int unsigned OUT = 4
) (
   input  logic [IN-1:0]             in,
   output logic [out_width(OUT)-1:0] out
);

   localparam tbl_e Tbl = tbl_sel(IN, OUT);

   if (Tbl == Tbl5x4) begin : g_5x4
      always_comb begin
         out = '0;
         unique case (in) inside
            [5'd0  : 5'd0 ]: out = 5'd0;
            [5'd1  : 5'd2 ]: out = 5'd1;
            [5'd3  : 5'd3 ]: out = 5'd2;
            [5'd4  : 5'd5 ]: out = 5'd3;
            [5'd6  : 5'd6 ]: out = 5'd4;
            [5'd7  : 5'd8 ]: out = 5'd5;
            [5'd9  : 5'd10]: out = 5'd6;
            [5'd11 : 5'd12]: out = 5'd7;
            [5'd13 : 5'd14]: out = 5'd8;
            [5'd15 : 5'd16]: out = 5'd9;
            [5'd17 : 5'd18]: out = 5'd10;
            [5'd19 : 5'd20]: out = 5'd11;
            [5'd21 : 5'd22]: out = 5'd12;
            [5'd23 : 5'd25]: out = 5'd13;
            [5'd26 : 5'd27]: out = 5'd14;
            [5'd28 : 5'd30]: out = 5'd15;
            [5'd31 : 5'd31]: out = 5'd16;
            default:         out = '0;
         endcase
      end
   end else if (Tbl == Tbl8x4) begin : g_8x4
      always_comb begin
         out = '0;
         unique case (in) inside
            [8'd0   : 8'd5  ]: out = 5'd0;
            [8'd6   : 8'd17 ]: out = 5'd1;
            [8'd18  : 8'd29 ]: out = 5'd2;
            [8'd30  : 8'd41 ]: out = 5'd3;
            [8'd42  : 8'd55 ]: out = 5'd4;
            [8'd56  : 8'd68 ]: out = 5'd5;
            [8'd69  : 8'd83 ]: out = 5'd6;
            [8'd84  : 8'd98 ]: out = 5'd7;
            [8'd99  : 8'd113]: out = 5'd8;
            [8'd114 : 8'd130]: out = 5'd9;
            [8'd131 : 8'd147]: out = 5'd10;
            [8'd148 : 8'd165]: out = 5'd11;
            [8'd166 : 8'd183]: out = 5'd12;
            [8'd184 : 8'd203]: out = 5'd13;
            [8'd204 : 8'd223]: out = 5'd14;
            [8'd224 : 8'd245]: out = 5'd15;
            [8'd246 : 8'd255]: out = 5'd16;
            default:           out = '0;
         endcase
      end
   end else if (Tbl == Tbl8x5) begin : g_8x5
      always_comb begin
         out = '0;
         unique case (in) inside
            [8'd0   : 8'd2  ]: out = 6'd0;
            [8'd3   : 8'd8  ]: out = 6'd1;
            [8'd9   : 8'd14 ]: out = 6'd2;
            [8'd15  : 8'd20 ]: out = 6'd3;
            [8'd21  : 8'd26 ]: out = 6'd4;
            [8'd27  : 8'd32 ]: out = 6'd5;
            [8'd33  : 8'd38 ]: out = 6'd6;
            [8'd39  : 8'd45 ]: out = 6'd7;
            [8'd46  : 8'd51 ]: out = 6'd8;
            [8'd52  : 8'd58 ]: out = 6'd9;
            [8'd59  : 8'd65 ]: out = 6'd10;
            [8'd66  : 8'd72 ]: out = 6'd11;
            [8'd73  : 8'd79 ]: out = 6'd12;
            [8'd80  : 8'd86 ]: out = 6'd13;
            [8'd87  : 8'd94 ]: out = 6'd14;
            [8'd95  : 8'd102]: out = 6'd15;
            [8'd103 : 8'd109]: out = 6'd16;
            [8'd110 : 8'd117]: out = 6'd17;
            [8'd118 : 8'd126]: out = 6'd18;
            [8'd127 : 8'd134]: out = 6'd19;
            [8'd135 : 8'd143]: out = 6'd20;
            [8'd144 : 8'd151]: out = 6'd21;
            [8'd152 : 8'd160]: out = 6'd22;
            [8'd161 : 8'd169]: out = 6'd23;
            [8'd170 : 8'd179]: out = 6'd24;
            [8'd180 : 8'd188]: out = 6'd25;
            [8'd189 : 8'd198]: out = 6'd26;
            [8'd199 : 8'd208]: out = 6'd27;
            [8'd209 : 8'd218]: out = 6'd28;
            [8'd219 : 8'd229]: out = 6'd29;
            [8'd230 : 8'd239]: out = 6'd30;
            [8'd240 : 8'd250]: out = 6'd31;
            [8'd251 : 8'd255]: out = 6'd32;
            default:           out = '0;
         endcase
      end
   end else begin : g_none
      assign out = '0;
   end

endmodule

// File: rtl/log2_mem_lut.sv
// Registered log2(1 + in/2^IN) lookup, one result per cycle, latency 1.
// Define LOG2_MEM_PARAM_CHECK_EN to reject unsupported (IN,OUT) pairs at elaboration.
module log2_mem_lut
   import log2_mem_pkg::*;
#(
   parameter int unsigned IN  = 8,
   parameter int unsigned OUT = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [IN-1:0]             in,
   output logic                      out_valid,
   output logic [out_width(OUT)-1:0] out
);

   localparam int unsigned OW = out_width(OUT);

`ifdef LOG2_MEM_PARAM_CHECK_EN
   if (!is_supported(IN, OUT)) begin : g_param_check
      $fatal(1, "log2_mem_lut: unsupported (IN,OUT) pair");
   end
`else
`endif

   logic [OW-1:0] rom_out;
   logic [OW-1:0] out_d, out_q;
   logic          valid_q;

   log2_mem_rom #(
      .IN  (IN),
      .OUT (OUT)
   ) u_rom (
      .in  (in),
      .out (rom_out)
   );

   // Idle cycles keep the last result; only the valid flag drops.
   always_comb begin
      out_d = out_q;
      if (in_valid) out_d = rom_out;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= in_valid;
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_log2_mem_lut.sv
// Directed and exhaustive checks of log2_mem_lut for (5,4), (8,4), (8,5) and an unsupported pair.
module tb_log2_mem_lut;
   import log2_mem_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [4:0] in5;
   logic [7:0] in8;
   logic [5:0] in6;

   logic       v54, v84, v85, v63;
   logic [4:0] out54, out84;
   logic [5:0] out85;
   logic [3:0] out63;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   log2_mem_lut #(.IN(5), .OUT(4)) dut54 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in(in5), .out_valid(v54), .out(out54)
   );
   log2_mem_lut #(.IN(8), .OUT(4)) dut84 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in(in8), .out_valid(v84), .out(out84)
   );
   log2_mem_lut #(.IN(8), .OUT(5)) dut85 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in(in8), .out_valid(v85), .out(out85)
   );
   log2_mem_lut #(.IN(6), .OUT(3)) dut63 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in(in6), .out_valid(v63), .out(out63)
   );

   typedef struct {
      int pair;   // 0 = (5,4), 1 = (8,4), 2 = (8,5)
      int in;
      int exp;
   } vec_t;

   vec_t vecs [11];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int ref_log2(input int v, input int iw, input int ow);
      real f;
      f = real'(v) / real'(1 << iw);
      return int'($floor($ln(1.0 + f) / $ln(2.0) * real'(1 << ow) + 0.5));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int got, gotv;
      vecs[0]  = '{0, 0, 0};
      vecs[1]  = '{0, 8, 5};
      vecs[2]  = '{0, 16, 9};
      vecs[3]  = '{0, 31, 16};
      vecs[4]  = '{1, 0, 0};
      vecs[5]  = '{1, 128, 9};
      vecs[6]  = '{1, 255, 16};
      vecs[7]  = '{2, 1, 0};
      vecs[8]  = '{2, 64, 10};
      vecs[9]  = '{2, 128, 19};
      vecs[10] = '{2, 255, 32};

      reset = 1'b1; in_valid = 1'b1; in5 = 5'd31; in8 = 8'd255; in6 = 6'd63;
      step();
      check("rst_out54", int'(out54), 0);
      check("rst_v54",   int'(v54),   0);
      check("rst_out84", int'(out84), 0);
      check("rst_v84",   int'(v84),   0);
      check("rst_out85", int'(out85), 0);
      check("rst_v85",   int'(v85),   0);
      reset = 1'b0;

      foreach (vecs[k]) begin
         in5 = 5'(vecs[k].in); in8 = 8'(vecs[k].in); in_valid = 1'b1;
         step();
         case (vecs[k].pair)
            0:       begin got = int'(out54); gotv = int'(v54); end
            1:       begin got = int'(out84); gotv = int'(v84); end
            default: begin got = int'(out85); gotv = int'(v85); end
         endcase
         check($sformatf("vec%0d_out", k), got, vecs[k].exp);
         check($sformatf("vec%0d_valid", k), gotv, 1);
      end

      for (int i = 0; i < int'(RomDepth5); i++) begin
         in5 = 5'(i); in6 = 6'(i); in_valid = 1'b1;
         step();
         check($sformatf("sweep54[%0d]", i), int'(out54), ref_log2(i, 5, 4));
         check($sformatf("sweep54_valid[%0d]", i), int'(v54), 1);
         check($sformatf("unsup63[%0d]", i), int'(out63), 0);
         check($sformatf("unsup63_valid[%0d]", i), int'(v63), 1);
      end

      for (int i = 0; i < int'(RomDepth8); i++) begin
         in8 = 8'(i); in_valid = 1'b1;
         step();
         check($sformatf("sweep84[%0d]", i), int'(out84), ref_log2(i, 8, 4));
         check($sformatf("sweep84_valid[%0d]", i), int'(v84), 1);
         check($sformatf("sweep85[%0d]", i), int'(out85), ref_log2(i, 8, 5));
         check($sformatf("sweep85_valid[%0d]", i), int'(v85), 1);
      end

      // Reset wins over a valid input and discards the pending result.
      reset = 1'b1; in_valid = 1'b1; in8 = 8'd255;
      step();
      check("rstprio_out84", int'(out84), 0);
      check("rstprio_v84",   int'(v84),   0);
      check("rstprio_out85", int'(out85), 0);
      reset = 1'b0; in8 = 8'd128;
      step();
      check("postrst_out84", int'(out84), 9);
      check("postrst_v84",   int'(v84),   1);
      check("postrst_out85", int'(out85), 19);

      in_valid = 1'b0; in8 = 8'd255;
      step();
      check("hold1_out84", int'(out84), 9);
      check("hold1_v84",   int'(v84),   0);
      check("hold1_out85", int'(out85), 19);
      in8 = 8'd3;
      step();
      check("hold2_out84", int'(out84), 9);
      check("hold2_v84",   int'(v84),   0);
      check("hold2_v85",   int'(v85),   0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/log2_mem_lut.md
LOG2_MEM_LUT -- requirements
Module: log2_mem_lut

Interface
REQ-001 SHALL have parameter IN, default 8: input fraction width in bits.
REQ-002 SHALL have parameter OUT, default 4: output fraction width in bits.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  qualifies in for the current cycle.
REQ-006 SHALL have port in  input  IN  unsigned fraction f = in / 2^IN, in the range [0,1).
REQ-007 SHALL have port out_valid  output  1  out holds a valid result.
REQ-008 SHALL have port out  output  OUT+1  result; the extra MSB carries the value 2^OUT.

Function
REQ-009 SHALL compute out = round-to-nearest(log2(1 + in/2^IN) * 2^OUT).
- No rounding ties occur for any in > 0.
- in = 0 gives exactly 0.
REQ-010 SHALL produce results in the range 0..2^OUT inclusive, monotonic non-decreasing in in; the top codes of in may round to 2^OUT, with only the MSB set.
REQ-011 SHALL implement the mapping as a constant lookup table (case ROM) with 2^IN entries, and SHALL NOT evaluate logarithms at runtime.
REQ-012 SHALL register the result with latency exactly 1 cycle: out and out_valid are updated on the clock edge that samples in and in_valid.
REQ-013 SHALL set out_valid to the previous cycle's in_valid; it SHALL NOT use backpressure.
REQ-014 SHALL hold out at its last value when in_valid = 0; only out_valid drops.
REQ-015 SHALL accept a new input every cycle (throughput 1 per cycle); back-to-back valid inputs SHALL produce back-to-back results.
REQ-016 SHALL support exactly the (IN,OUT) pairs (5,4), (8,4) and (8,5).

Reset
REQ-017 SHALL drive out = 0 and out_valid = 0 on the first clock edge with reset = 1.
REQ-018 SHALL give reset priority over in_valid when both are asserted in the same cycle; the input is discarded.
REQ-019 SHALL, when reset is asserted while a result is pending, discard that result; out_valid is 0 in the following cycle.
REQ-020 SHALL produce normal results starting the cycle after reset is deasserted.

Configuration
REQ-021 SHALL, when macro LOG2_MEM_PARAM_CHECK_EN is defined, raise an elaboration-time fatal error for any (IN,OUT) pair other than the three supported pairs.
REQ-022 SHALL, when LOG2_MEM_PARAM_CHECK_EN is not defined, perform no check; an unsupported pair then drives out = 0 constantly and out_valid behaves normally.

Structure
REQ-023 SHALL take from a shared package log2_mem_pkg:
- the list of supported (IN,OUT) pairs;
- a function giving the output width (OUT+1);
- the ROM depth localparams.
REQ-024 SHALL place the three tables in one combinational sub-module, log2_mem_rom, parameterized by IN and OUT and selected by generate.
REQ-025 SHALL contain only the pipeline register and valid flop in the top-level log2_mem_lut.

Verification
REQ-026 SHALL cover (5,4): in = 0, 8, 16, 31 with in_valid = 1 -> out = 0, 5, 9, 16 one cycle later, with out_valid = 1.
REQ-027 SHALL cover (8,4): in = 0, 128, 255 -> out = 0, 9, 16.
REQ-028 SHALL cover (8,5): in = 1, 64, 128, 255 -> out = 0, 10, 19, 32.
REQ-029 SHALL cover an exhaustive sweep for each supported pair: every in value is sent back-to-back, and each out matches the REQ-009 reference model, with out_valid high throughout.
REQ-030 SHALL cover reset: reset = 1 together with in_valid = 1 and in = 255 -> next cycle out = 0 and out_valid = 0; after reset is released, in = 128 -> out = 9 (8,4).
REQ-031 SHALL cover the hold case: in_valid = 0 with in changing -> out holds its last value and out_valid = 0.
